// File: rtl/esi_cosim_frame_pkg.sv
// Shared definitions for the cosim frame splitter and the future to-host frame joiner.
// Frame counts, index widths and the two-state splitter FSM encoding.
package esi_cosim_frame_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } frame_split_state_e;

    // Ceiling division; a zero frame width is rejected at elaboration by the user.
    function automatic int num_frames(input int msg_bits, input int frame_bits);
        if (frame_bits < 1) return 1;
        return (msg_bits + frame_bits - 1) / frame_bits;
    endfunction

    function automatic int frame_idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/esi_cosim_frame_splitter_if.sv
// Message-in / frame-out handshake bundle of the cosim frame splitter.
// master = splitter side, slave = surrounding environment.
interface esi_cosim_frame_splitter_if #(
    parameter int MSG_BITS   = 100,
    parameter int FRAME_BITS = 32
);
    import esi_cosim_frame_pkg::*;

    localparam int NUM_FRAMES = num_frames(MSG_BITS, FRAME_BITS);
    localparam int IDX_BITS   = frame_idx_bits(NUM_FRAMES);

    logic                  MsgValid;
    logic                  MsgReady;
    logic [MSG_BITS-1:0]   Msg;
    logic                  FrameValid;
    logic                  FrameReady;
    logic [FRAME_BITS-1:0] Frame;
    logic [IDX_BITS-1:0]   FrameIdx;
    logic                  FrameLast;

    modport master (
        input  MsgValid, Msg, FrameReady,
        output MsgReady, FrameValid, Frame, FrameIdx, FrameLast
    );

    modport slave (
        output MsgValid, Msg, FrameReady,
        input  MsgReady, FrameValid, Frame, FrameIdx, FrameLast
    );

endinterface

// File: rtl/esi_cosim_frame_splitter.sv
// Splits one wide host message into NUM_FRAMES narrow frames, least-significant first,
// accepting the next message on the last frame's handshake so messages run back-to-back.
module esi_cosim_frame_splitter
    import esi_cosim_frame_pkg::*;
#(
    parameter int MSG_BITS   = 100,
    parameter int FRAME_BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    esi_cosim_frame_splitter_if.master io,
    output logic [15:0]                MsgsSent
);

    localparam int NUM_FRAMES = num_frames(MSG_BITS, FRAME_BITS);
    localparam int IDX_BITS   = frame_idx_bits(NUM_FRAMES);
    localparam int HOLD_BITS  = NUM_FRAMES * FRAME_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_FRAMES - 1);

    generate
        if (MSG_BITS < 1 || FRAME_BITS < 1) begin : g_bad_params
            $error("esi_cosim_frame_splitter: MSG_BITS and FRAME_BITS must both be >= 1");
        end
    endgenerate

    frame_split_state_e    state_q, state_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [HOLD_BITS-1:0]  hold_q, hold_d;
    logic [15:0]           sent_q, sent_d;
    logic [FRAME_BITS-1:0] frame_mux;
    logic                  last;
    logic                  frame_hs;
    logic                  msg_hs;

    assign last     = (idx_q == LAST_IDX);
    assign frame_hs = io.FrameValid && io.FrameReady;
    // Combinational FrameReady -> MsgReady path lets the next message load on the last frame's edge.
    assign msg_hs   = io.MsgValid && io.MsgReady;

    assign io.FrameValid = (state_q == SEND);
    assign io.MsgReady   = (state_q == IDLE) || (frame_hs && last);
    assign io.FrameIdx   = idx_q;
    assign io.FrameLast  = last;
    assign io.Frame      = frame_mux;
    assign MsgsSent      = sent_q;

    always_comb begin
        frame_mux = '0;
        for (int i = 0; i < NUM_FRAMES; i++) begin
            if (idx_q == IDX_BITS'(i)) frame_mux = hold_q[i*FRAME_BITS +: FRAME_BITS];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        sent_d  = sent_q;

        if (frame_hs) begin
            if (last) begin
                sent_d  = sent_q + 16'd1;
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_BITS'(1);
            end
        end

        // A new message overrides the return to IDLE; unused upper bits stay zero as padding.
        if (msg_hs) begin
            hold_d                 = '0;
            hold_d[MSG_BITS-1:0]   = io.Msg;
            idx_d                  = '0;
            state_d                = SEND;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            sent_q  <= sent_d;
        end
    end

endmodule

// File: doc/esi_cosim_frame_splitter.md
Name: esi_cosim_frame_splitter

Overview:
- Sits directly downstream of the cosim from-host endpoint.
- Accepts one wide message per valid/ready handshake and emits it as a sequence of narrower frames over a second valid/ready channel.
- Frames go out least-significant first, tagged with a frame index and a last flag.
- Lets host-injected wide messages feed narrow datapaths without a bubble between messages.

Parameters:
- MSG_BITS, 100, width of the incoming message; must be >= 1.
- FRAME_BITS, 32, width of each outgoing frame; must be >= 1.
- Derived localparam NUM_FRAMES = (MSG_BITS+FRAME_BITS-1)/FRAME_BITS.
- Derived localparam IDX_BITS = max(1, $clog2(NUM_FRAMES)).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- MsgValid  in  1  upstream message valid.
- MsgReady  out  1  splitter can accept a message this cycle.
- Msg  in  MSG_BITS  upstream message payload.
- FrameValid  out  1  current frame valid.
- FrameReady  in  1  downstream accepts frame.
- Frame  out  FRAME_BITS  current frame payload.
- FrameIdx  out  IDX_BITS  index of current frame, 0..NUM_FRAMES-1.
- FrameLast  out  1  high when FrameIdx == NUM_FRAMES-1.
- MsgsSent  out  16  count of fully emitted messages; wraps modulo 2^16.

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE, idx = 0, holding register = 0, MsgsSent = 0.
  - FrameValid drops to 0 immediately, without waiting for a clock edge.
  - Any in-flight message is discarded; no partial frames are emitted after release.
- Holding register:
  - Width NUM_FRAMES*FRAME_BITS.
  - Loaded with Msg zero-extended on every message handshake (MsgValid && MsgReady at posedge).
- FSM, two states:
  - IDLE: FrameValid = 0, MsgReady = 1. A handshake loads the register, sets idx = 0, moves to SEND.
  - SEND: FrameValid = 1.
    - Frame = holding[idx*FRAME_BITS +: FRAME_BITS].
    - On a frame handshake with idx < NUM_FRAMES-1: idx increments.
    - On a frame handshake with FrameLast: MsgsSent increments.
      - If a message handshake occurs in the same cycle: reload, idx = 0, stay in SEND.
      - Otherwise: go to IDLE, idx = 0.
- MsgReady = (state == IDLE) || (FrameValid && FrameReady && FrameLast).
  - This is a combinational FrameReady->MsgReady path, by design, for zero-bubble back-to-back messages.
- Latency:
  - Message accepted at edge N -> frame 0 visible in cycle N+1.
  - Steady-state throughput: NUM_FRAMES cycles per message with FrameReady held high.
- Stability rule: while FrameValid && !FrameReady, Frame, FrameIdx and FrameLast hold stable. FrameValid never deasserts without a handshake, except under reset.
- Padding: bits of the last frame above MSG_BITS-1 are driven 0. Example: MSG_BITS=100, FRAME_BITS=32 -> frame 3 bits [31:4] = 0.
- NUM_FRAMES == 1:
  - Every frame is last and FrameIdx is always 0.
  - Module degenerates to a one-entry, full-throughput register stage.
- FRAME_BITS >= MSG_BITS is legal: one frame, zero-padded.
- MsgValid while in SEND and not on the last handshake: MsgReady = 0 and upstream holds. No message is ever dropped.
- MsgsSent: 0xFFFF + 1 -> 0x0000, no flag.
- Elaboration: $error if MSG_BITS < 1 or FRAME_BITS < 1.

Decomposition:
- Shared package esi_cosim_frame_pkg holds:
  - function num_frames(msg_bits, frame_bits), returning the ceiling division;
  - function frame_idx_bits(n), returning max(1, $clog2(n));
  - the two-state enum typedef frame_split_state_e {IDLE, SEND}.
- The same package will serve the future to-host frame joiner.
- No sub-module: the FSM, counter and mux are small enough to live in one module.

Test Plan:
- MSG_BITS=100, FRAME_BITS=32, FrameReady=1, Msg=100'h0F_1234_5678_9ABC_DEF0_1122_3344 -> frames 0x11223344, 0x9ABCDEF0, 0x12345678, 0x0000000F on consecutive cycles.
  - FrameIdx reads 0, 1, 2, 3; FrameLast only on idx 3; MsgsSent = 1.
- Back-to-back: two messages with MsgValid held high and FrameReady=1 -> 8 consecutive valid frames with no gap.
  - MsgReady is high exactly on the cycles of idx 3 and initial IDLE; MsgsSent = 2.
- Backpressure: FrameReady low for 5 cycles at idx 1 -> Frame, FrameIdx and FrameValid constant for those 5 cycles.
  - MsgReady stays 0; sequence resumes at idx 1 with no skipped or repeated frames.
- Reset mid-message: assert rst low between edges at idx 2 -> FrameValid goes 0 before the next posedge and MsgsSent = 0.
  - After release a new message starts at idx 0 and no stale frames appear.
- MSG_BITS=8, FRAME_BITS=32, Msg=8'hA5 -> single frame 0x000000A5, FrameLast=1, FrameIdx=0.
  - With MsgValid held high, a new message is accepted every cycle.
- Counter wrap: force 65536 messages with MSG_BITS=FRAME_BITS=8 -> MsgsSent returns to 0x0000, no other output disturbed.
